floor_call_dispatcher: RTL



---
 rtl/elevator_pkg.sv | 24 ++
 rtl/floor_call_dispatcher_if.sv | 27 ++
 rtl/floor_call_dispatcher_call_target_select.sv | 75 +++++++
 rtl/floor_call_dispatcher.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// -----------------------------------------------------------------------------
// elevator_pkg
// Shared types and constants for the floor call dispatcher slice.
//   dispatch_state_t : dispatcher FSM states
//   DIR_UP/DIR_DOWN  : encoding of the SCAN travel direction (moving_dir)
//   DEFAULT_FLOORS   : default number of served floors
// -----------------------------------------------------------------------------
package elevator_pkg;

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      WAIT_START = 3'd1,
      MOVING     = 3'd2,
      ARRIVE     = 3'd3,
      DOOR       = 3'd4,
      FAULT      = 3'd5
   } dispatch_state_t;

   localparam logic DIR_UP   = 1'b0;
   localparam logic DIR_DOWN = 1'b1;

   localparam int unsigned DEFAULT_FLOORS = 4;

endpackage

// File: rtl/floor_call_dispatcher_if.sv
// -----------------------------------------------------------------------------
// floor_call_dispatcher_if
// Command/status link between the dispatcher and main_motor.
//   floor_move_cnt  : signed relative floor count (dispatcher -> motor)
//   move_stop_start : one-cycle start pulse        (dispatcher -> motor)
//   moving_check    : motor busy flag              (motor -> dispatcher)
// Modports: master = dispatcher side, slave = motor side.
// -----------------------------------------------------------------------------
interface floor_call_dispatcher_if;

   logic signed [31:0] floor_move_cnt;
   logic               move_stop_start;
   logic               moving_check;

   modport master (
      output floor_move_cnt,
      output move_stop_start,
      input  moving_check
   );

   modport slave (
      input  floor_move_cnt,
      input  move_stop_start,
      output moving_check
   );

endinterface

// File: rtl/floor_call_dispatcher_call_target_select.sv
// -----------------------------------------------------------------------------
// call_target_select
// Combinational SCAN chooser: keeps travelling in the current direction while
// calls remain ahead, otherwise turns around to the nearest call behind.
//   pending       : latched call register (bit i = floor i)
//   current_floor : floor the car is standing at (its own bit is ignored)
//   moving_dir    : present SCAN direction
//   target        : chosen floor (valid only when valid=1)
//   new_dir       : direction after this choice
//   valid         : at least one pending call other than current_floor
// -----------------------------------------------------------------------------
module call_target_select import elevator_pkg::*; #(
   parameter int unsigned FLOORS  = DEFAULT_FLOORS,
   parameter int unsigned FLOOR_W = $clog2(FLOORS)
) (
   input  logic [FLOORS-1:0]  pending,
   input  logic [FLOOR_W-1:0] current_floor,
   input  logic               moving_dir,
   output logic [FLOOR_W-1:0] target,
   output logic               new_dir,
   output logic               valid
);

   logic               found_up;
   logic               found_dn;
   logic [FLOOR_W-1:0] up_t;
   logic [FLOOR_W-1:0] dn_t;

   always_comb begin
      // NOTE: every variable written here gets a default first so no path
      // leaves it unassigned, which would otherwise infer a latch.
      found_up = 1'b0;
      found_dn = 1'b0;
      up_t     = '0;
      dn_t     = '0;
      // Descending scan: the last hit is the nearest floor above.
      for (int i = int'(FLOORS) - 1; i >= 0; i--) begin
         if (pending[i] && (i > int'(current_floor))) begin
            found_up = 1'b1;
            up_t     = FLOOR_W'(i);
         end
      end
      // Ascending scan: the last hit is the nearest floor below.
      for (int i = 0; i < int'(FLOORS); i++) begin
         if (pending[i] && (i < int'(current_floor))) begin
            found_dn = 1'b1;
            dn_t     = FLOOR_W'(i);
         end
      end
   end

   always_comb begin
      target  = current_floor;
      new_dir = moving_dir;
      valid   = found_up | found_dn;
      if (moving_dir == DIR_UP) begin
         if (found_up) begin
            target  = up_t;
            new_dir = DIR_UP;
         end else if (found_dn) begin
            target  = dn_t;
            new_dir = DIR_DOWN;
         end
      end else begin
         if (found_dn) begin
            target  = dn_t;
            new_dir = DIR_DOWN;
         end else if (found_up) begin
            target  = up_t;
            new_dir = DIR_UP;
         end
      end
   end

endmodule

// File: rtl/floor_call_dispatcher.sv
// -----------------------------------------------------------------------------
// floor_call_dispatcher
// Latches floor calls, picks the next floor in SCAN order, commands main_motor
// with a relative floor count plus start pulse, waits for the motor to settle,
// then holds the door open before dispatching again.
//   floor_clk, floor_reset : clock, asynchronous active-high reset
//   call_req               : level call buttons, bit i = floor i
//   door_hold              : keeps the door open (only with DOOR_HOLD_EN)
//   motor_bus (master)     : floor_move_cnt / move_stop_start out, moving_check in
//   current_floor          : last arrived floor
//   moving_dir             : SCAN direction, 0 = up, 1 = down
//   door_open              : high while the door is open
//   pending_calls          : latched call register
//   fault                  : sticky start-timeout fault
// Optional build macro: DOOR_HOLD_EN adds door_hold and lets a call for the
// current floor reload the door timer.
// -----------------------------------------------------------------------------
module floor_call_dispatcher import elevator_pkg::*; #(
   parameter int unsigned FLOORS        = DEFAULT_FLOORS,
   parameter int unsigned FLOOR_W       = $clog2(FLOORS),
   parameter logic [31:0] DOOR_CYCLES   = 32'd50_000_000,
   parameter logic [31:0] SETTLE_CYCLES = 32'd1000,
   parameter logic [31:0] START_TIMEOUT = 32'd1000
) (
   input  logic                    floor_clk,
   input  logic                    floor_reset,
   input  logic [FLOORS-1:0]       call_req,
`ifdef DOOR_HOLD_EN
   input  logic                    door_hold,
`endif
   floor_call_dispatcher_if.master motor_bus,
   output logic [FLOOR_W-1:0]      current_floor,
   output logic                    moving_dir,
   output logic                    door_open,
   output logic [FLOORS-1:0]       pending_calls,
   output logic                    fault
);

   dispatch_state_t    state_q, state_d;
   logic [31:0]        cnt_q, cnt_d;
   logic [FLOORS-1:0]  pending_q, pending_d;
   logic [FLOOR_W-1:0] cur_q, cur_d;
   logic [FLOOR_W-1:0] target_q, target_d;
   logic               dir_q, dir_d;
   logic signed [31:0] move_cnt_q, move_cnt_d;
   logic               start_q, start_d;
   logic               door_q;
   logic               fault_q;

   logic [FLOOR_W-1:0] sel_target;
   logic               sel_dir;
   logic               sel_valid;
   logic signed [FLOOR_W:0] diff;
   logic               here_call;
   logic               door_reload;

   call_target_select #(
      .FLOORS  (FLOORS),
      .FLOOR_W (FLOOR_W)
   ) u_select (
      .pending       (pending_q),
      .current_floor (cur_q),
      .moving_dir    (dir_q),
      .target        (sel_target),
      .new_dir       (sel_dir),
      .valid         (sel_valid)
   );

   assign here_call = call_req[cur_q];
   // Zero-extended operands give a difference that always fits FLOOR_W+1 bits.
   assign diff = $signed({1'b0, sel_target}) - $signed({1'b0, cur_q});

`ifdef DOOR_HOLD_EN
   assign door_reload = door_hold | here_call;
`else
   assign door_reload = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      cur_d      = cur_q;
      target_d   = target_q;
      dir_d      = dir_q;
      move_cnt_d = move_cnt_q;
      start_d    = 1'b0;
      pending_d  = pending_q | call_req;
      // A call for the floor the car is standing at is served by the door,
      // never queued as a trip.
      if ((state_q == IDLE) || (state_q == DOOR)) begin
         pending_d[cur_q] = pending_q[cur_q];
      end

      case (state_q)
         IDLE: begin
            if (here_call) begin
               state_d = DOOR;
               cnt_d   = '0;
            end else if (sel_valid) begin
               target_d   = sel_target;
               dir_d      = sel_dir;
               move_cnt_d = {{(31 - FLOOR_W){diff[FLOOR_W]}}, diff};
               start_d    = 1'b1;
               state_d    = WAIT_START;
               cnt_d      = '0;
            end
         end
         WAIT_START: begin
            if (motor_bus.moving_check) begin
               state_d = MOVING;
               cnt_d   = '0;
            end else if (cnt_q == START_TIMEOUT - 32'd1) begin
               state_d = FAULT;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         MOVING: begin
            // Only an unbroken run of idle clocks counts; overshoot blips
            // restart the run.
            if (motor_bus.moving_check) begin
               cnt_d = '0;
            end else if (cnt_q == SETTLE_CYCLES - 32'd1) begin
               state_d = ARRIVE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         ARRIVE: begin
            cur_d               = target_q;
            pending_d[target_q] = 1'b0;
            state_d             = DOOR;
            cnt_d               = '0;
         end
         DOOR: begin
            if (door_reload) begin
               cnt_d = '0;
            end else if (cnt_q == DOOR_CYCLES - 32'd1) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         FAULT: begin
            state_d = FAULT;
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge floor_clk or posedge floor_reset) begin
      if (floor_reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         pending_q  <= '0;
         cur_q      <= '0;
         target_q   <= '0;
         dir_q      <= DIR_UP;
         move_cnt_q <= '0;
         start_q    <= 1'b0;
         door_q     <= 1'b0;
         fault_q    <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register updates from
         // values sampled before this edge, independent of statement order.
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         pending_q  <= pending_d;
         cur_q      <= cur_d;
         target_q   <= target_d;
         dir_q      <= dir_d;
         move_cnt_q <= move_cnt_d;
         start_q    <= start_d;
         door_q     <= (state_d == DOOR);
         fault_q    <= (state_d == FAULT);
      end
   end

   assign motor_bus.floor_move_cnt  = move_cnt_q;
   assign motor_bus.move_stop_start = start_q;
   assign current_floor             = cur_q;
   assign moving_dir                = dir_q;
   assign door_open                 = door_q;
   assign pending_calls             = pending_q;
   assign fault                     = fault_q;

endmodule
